data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Target end of the core's data-memory request interface (request / we_re / mask / address / store data out; valid / load data back).
- Accepts one word-sized load or store at a time and applies byte-lane write masking.
- Inserts a programmable number of wait states, then returns a one-cycle valid pulse with read data.
- Sits between the core's memory stage and a word-organised on-chip RAM; also usable as the instruction-memory responder with stores tied off.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- WAIT_CYCLES, 2, wait states between acceptance and response (0..15).
- ADDR_BITS, 10, log2(DEPTH_WORDS); word-index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- request  input  1  transaction request from the core; held high until valid is seen.
- we_re  input  1  1 = store, 0 = load.
- mask  input  4  byte-lane enables; bit i covers data[8i+7:8i].
- address  input  32  byte address; bits [1:0] ignored.
- store_data  input  32  write data, already lane-aligned by the core.
- valid  output  1  one-cycle response pulse.
- load_data  output  32  read word; meaningful only when valid=1.
- error  output  1  qualifies valid: address out of range.
- busy  output  1  high from acceptance until the response cycle, inclusive.

Behaviour:
- Reset (async, active-high): state=IDLE, valid=0, error=0, busy=0, load_data=0, wait counter=0. RAM contents are not reset.
- Reset asserted mid-transaction aborts it. A pending store is not written, and no valid pulse is produced after reset release.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with request=1, capture we_re, mask, address, store_data into holding registers and raise busy.
  - Go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, otherwise go directly to RESP.
- WAIT:
  - Counter decrements each cycle; input changes are ignored because captured values are used.
  - When counter=0, next state is RESP.
- Transition into RESP:
  - Store: for each lane with mask[i]=1, write that lane of the word at address[ADDR_BITS+1:2]; other lanes are unchanged.
  - Load: register the full 32-bit word into load_data; mask does not affect read data.
- RESP: valid=1 for exactly one cycle, then return to IDLE. busy deasserts as the FSM leaves RESP.
- Latency: for acceptance at edge N, valid is high in the cycle following edge N+WAIT_CYCLES. That is WAIT_CYCLES+1 cycles.
- Back-to-back requests: the core drops request in the cycle after valid. If request is still high at the first IDLE edge, it is accepted as a new transaction. The responder never skips a request seen in IDLE.
- Request toggled during WAIT or RESP has no effect.
- Out of range (address[31:ADDR_BITS+2] != 0):
  - Store is suppressed; load returns load_data=0.
  - error=1 together with valid, same cycle only; timing is otherwise identical.
- mask=4'b0000 on a store: no RAM change, normal valid pulse.
- Store on a load-only deployment (instruction side): the we_re input is tied to 0 by the integrator; the block does not distinguish.
- Writes to the same word on consecutive transactions are resolved strictly in order. A load after a store returns the updated value.

Decomposition:
- Package mem_resp_pkg holds:
  - The state enum (IDLE, WAIT, RESP).
  - Localparams for the we_re encoding (WE_STORE=1, WE_LOAD=0).
  - Lane width (8) and word bytes (4).
- One sub-module, mem_word_ram: synchronous single-port RAM with DEPTH_WORDS×32 storage, per-byte write enables, registered read.
- The FSM, holding registers, counter and range check stay in data_mem_responder.

Test Plan:
- Reset then store 32'hDEADBEEF to address 0x10 with mask 4'hF, WAIT_CYCLES=2 -> valid high in cycle 3 after acceptance, error=0. A following load from 0x10 returns 32'hDEADBEEF.
- Store 32'h000000AA with mask 4'b0001 to 0x10 (holding DEADBEEF) -> subsequent load returns 32'hDEADBEAA. Then store 32'h12340000 with mask 4'b1100 -> load returns 32'h1234BEAA.
- WAIT_CYCLES=0: load from 0x20 -> valid exactly one cycle after the acceptance edge, busy high for exactly one cycle.
- Load from 0x0000_1000 with DEPTH_WORDS=1024 -> valid=1, error=1, load_data=0. A store to the same address leaves all RAM words unchanged.
- Assert rst during WAIT of a store of 32'hCAFEF00D to 0x04 -> no valid pulse, busy=0 immediately, and a later load of 0x04 returns the prior contents.
- Request held high continuously across two transactions with changing address -> two valid pulses separated by one IDLE cycle. Each uses the address sampled at its own acceptance edge; changes during WAIT are ignored.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the data-memory responder slice:
//   state_t     - responder FSM states (IDLE, WAIT, RESP)
//   WE_STORE    - we_re value that marks a store
//   WE_LOAD     - we_re value that marks a load
//   LANE_WIDTH  - bits per byte lane
//   WORD_BYTES  - byte lanes per memory word
//   WORD_WIDTH  - bits per memory word
// ---------------------------------------------------------------------------
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic WE_STORE   = 1'b1;
    localparam logic WE_LOAD    = 1'b0;

    localparam int   LANE_WIDTH = 8;
    localparam int   WORD_BYTES = 4;
    localparam int   WORD_WIDTH = LANE_WIDTH * WORD_BYTES;

endpackage

// File: rtl/mem_word_ram.sv
// ---------------------------------------------------------------------------
// mem_word_ram
// Synchronous single-port word RAM with per-byte write enables and a
// registered read port. Contents are never reset.
// Ports:
//   clk      - clock, rising edge
//   rd_en    - load the read register from mem[addr]
//   byte_en  - per-lane write enables, bit i covers wr_data[8i+7:8i]
//   addr     - word index
//   wr_data  - write word, lane aligned
//   rd_data  - registered read word
// ---------------------------------------------------------------------------
module mem_word_ram
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [WORD_BYTES-1:0] byte_en,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic [WORD_WIDTH-1:0] rd_data
);

    logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

    // Lane-masked write and registered read share one port; the responder
    // never asks for both in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_en[i]) begin
                mem[addr][i*LANE_WIDTH +: LANE_WIDTH] <= wr_data[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Target end of the core's data-memory interface. Accepts one word load or
// store at a time, waits WAIT_CYCLES cycles, then pulses valid for one cycle
// with the read word (loads) and an out-of-range error flag.
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   request     - transaction request, held by the core until valid
//   we_re       - 1 = store, 0 = load
//   mask        - byte-lane enables for stores
//   address     - byte address, bits [1:0] ignored
//   store_data  - lane-aligned store word
//   valid       - one-cycle response pulse
//   load_data   - read word, meaningful while valid is high
//   error       - qualifies valid: address out of range
//   busy        - high from acceptance through the response cycle
// ---------------------------------------------------------------------------
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    input  logic                  we_re,
    input  logic [WORD_BYTES-1:0] mask,
    input  logic [31:0]           address,
    input  logic [WORD_WIDTH-1:0] store_data,
    output logic                  valid,
    output logic [WORD_WIDTH-1:0] load_data,
    output logic                  error,
    output logic                  busy
);

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                state;
    state_t                next_state;
    logic [3:0]            wait_cnt;

    logic                  hold_we;
    logic [WORD_BYTES-1:0] hold_mask;
    logic [ADDR_BITS-1:0]  hold_index;
    logic                  hold_oor;
    logic [WORD_WIDTH-1:0] hold_data;

    logic                  accept;
    logic                  in_oor;
    logic [ADDR_BITS-1:0]  in_index;

    logic                  cur_we;
    logic [WORD_BYTES-1:0] cur_mask;
    logic [ADDR_BITS-1:0]  cur_index;
    logic                  cur_oor;
    logic [WORD_WIDTH-1:0] cur_data;

    logic                  ram_rd_en;
    logic [WORD_BYTES-1:0] ram_byte_en;
    logic [WORD_WIDTH-1:0] ram_rd_data;

    assign in_oor   = (address >> (ADDR_BITS + 2)) != 32'd0;
    assign in_index = address[ADDR_BITS+1:2];
    assign accept   = (state == IDLE) && request;

    // With zero wait states the RAM access happens on the acceptance edge
    // itself, before the holding registers are loaded, so the live inputs
    // are used while idle and the captured copies otherwise.
    always_comb begin
        cur_we    = hold_we;
        cur_mask  = hold_mask;
        cur_index = hold_index;
        cur_oor   = hold_oor;
        cur_data  = hold_data;
        if (state == IDLE) begin
            cur_we    = we_re;
            cur_mask  = mask;
            cur_index = in_index;
            cur_oor   = in_oor;
            cur_data  = store_data;
        end
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Holding registers freeze the request at acceptance so the core's
    // inputs are free to change while we wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_we    <= WE_LOAD;
            hold_mask  <= '0;
            hold_index <= '0;
            hold_oor   <= 1'b0;
            hold_data  <= '0;
        end else if (accept) begin
            hold_we    <= we_re;
            hold_mask  <= mask;
            hold_index <= in_index;
            hold_oor   <= in_oor;
            hold_data  <= store_data;
        end
    end

    // Wait-state counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_INIT;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Next state, response outputs and RAM strobes. The RAM is touched only
    // on the edge that enters RESP, so an aborted transaction never writes.
    // The RAM's registered read stands in for the load_data register; it is
    // gated so stores, out-of-range loads and non-response cycles read 0.
    always_comb begin
        next_state  = state;
        valid       = 1'b0;
        error       = 1'b0;
        busy        = 1'b0;
        load_data   = '0;
        ram_rd_en   = 1'b0;
        ram_byte_en = '0;

        case (state)
            IDLE: begin
                if (request) begin
                    next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (wait_cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                busy       = 1'b1;
                valid      = 1'b1;
                error      = hold_oor;
                next_state = IDLE;
                if ((hold_we == WE_LOAD) && !hold_oor) begin
                    load_data = ram_rd_data;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if ((next_state == RESP) && (state != RESP) && !cur_oor) begin
            if (cur_we == WE_STORE) begin
                ram_byte_en = cur_mask;
            end else begin
                ram_rd_en = 1'b1;
            end
        end
    end

    mem_word_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_BITS   (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .rd_en   (ram_rd_en),
        .byte_en (ram_byte_en),
        .addr    (cur_index),
        .wr_data (cur_data),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Two responders share the request-data inputs: dut_a with two wait states
// and dut_b with none. A word-array model of the first sixteen RAM words of
// each instance predicts load data, error and response timing.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a;
    logic        req_b;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] address;
    logic [31:0] store_data;

    logic        valid_a, error_a, busy_a;
    logic [31:0] load_a;
    logic        valid_b, error_b, busy_b;
    logic [31:0] load_b;

    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [31:0] model [2][16];
    logic [31:0] got;

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2),
        .ADDR_BITS   (10)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .request    (req_a),
        .we_re      (we_re),
        .mask       (mask),
        .address    (address),
        .store_data (store_data),
        .valid      (valid_a),
        .load_data  (load_a),
        .error      (error_a),
        .busy       (busy_a)
    );

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (0),
        .ADDR_BITS   (10)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .request    (req_b),
        .we_re      (we_re),
        .mask       (mask),
        .address    (address),
        .store_data (store_data),
        .valid      (valid_b),
        .load_data  (load_b),
        .error      (error_b),
        .busy       (busy_b)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net in case the run never reaches its summary.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // One transaction on instance sel (0 = dut_a, 1 = dut_b), called at a
    // negedge with the target idle. Timing follows the rule that valid is
    // seen in the cycle after edge N+W for acceptance at edge N. Inputs
    // are scrambled while waiting. keep_req leaves request high after the
    // response so the next call is accepted back to back.
    task automatic applyStimulus(input int sel, input logic we, input logic [3:0] m,
                                 input logic [31:0] a, input logic [31:0] d,
                                 input bit keep_req, output logic [31:0] observed);
        int          w;
        int          idx;
        bit          oor;
        logic        v, b, e;
        logic [31:0] ld;
        w   = (sel != 0) ? 0 : 2;
        oor = (a >> 12) != 32'd0;
        idx = int'(a[5:2]);
        observed = '0;

        we_re      = we;
        mask       = m;
        address    = a;
        store_data = d;
        if (sel != 0) req_b = 1'b1; else req_a = 1'b1;
        @(posedge clk);

        for (int k = 0; k <= w; k++) begin
            @(negedge clk);
            v  = (sel != 0) ? valid_b : valid_a;
            b  = (sel != 0) ? busy_b  : busy_a;
            e  = (sel != 0) ? error_b : error_a;
            ld = (sel != 0) ? load_b  : load_a;
            checkOutput("busy_during_txn", {31'b0, b}, 32'd1);
            if (k < w) begin
                checkOutput("valid_too_early", {31'b0, v}, 32'd0);
                we_re      = 1'($urandom);
                mask       = 4'($urandom);
                address    = $urandom;
                store_data = $urandom;
                req_a      = 1'($urandom);
            end else begin
                checkOutput("valid_on_time", {31'b0, v}, 32'd1);
                checkOutput("error_flag", {31'b0, e}, {31'b0, oor});
                if (we == 1'b0) begin
                    checkOutput("load_data", ld, oor ? 32'd0 : model[sel][idx]);
                end
                observed = ld;
                if (sel != 0) req_b = keep_req; else req_a = keep_req;
            end
        end

        if (we && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) model[sel][idx][8*i +: 8] = d[8*i +: 8];
            end
        end

        @(negedge clk);
        v = (sel != 0) ? valid_b : valid_a;
        b = (sel != 0) ? busy_b  : busy_a;
        checkOutput("valid_one_cycle", {31'b0, v}, 32'd0);
        checkOutput("busy_released", {31'b0, b}, 32'd0);
    endtask

    // Main sequence: reset, model preload, directed cases, random traffic.
    initial begin
        int          sel;
        int          idx;
        logic        we;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] d;

        rst        = 1'b1;
        req_a      = 1'b0;
        req_b      = 1'b0;
        we_re      = 1'b0;
        mask       = 4'h0;
        address    = '0;
        store_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_valid_a", {31'b0, valid_a}, 32'd0);
        checkOutput("reset_busy_a",  {31'b0, busy_a},  32'd0);
        checkOutput("reset_error_a", {31'b0, error_a}, 32'd0);
        checkOutput("reset_load_a",  load_a, 32'd0);
        checkOutput("reset_valid_b", {31'b0, valid_b}, 32'd0);
        checkOutput("reset_busy_b",  {31'b0, busy_b},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                applyStimulus(s, 1'b1, 4'hF, 32'(i) << 2, $urandom, 1'b0, got);
            end
        end

        applyStimulus(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, got);
        applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, got);
        checkOutput("dir_deadbeef", got, 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 4'b0001, 32'h10, 32'h000000AA, 1'b0, got);
        applyStimulus(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, got);
        checkOutput("dir_deadbeaa", got, 32'hDEADBEAA);
        applyStimulus(0, 1'b1, 4'b1100, 32'h10, 32'h12340000, 1'b0, got);
        applyStimulus(0, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, got);
        checkOutput("dir_1234beaa", got, 32'h1234BEAA);

        applyStimulus(1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, got);

        applyStimulus(0, 1'b0, 4'hF, 32'h1000, 32'h0, 1'b0, got);
        applyStimulus(0, 1'b1, 4'hF, 32'h1000, 32'h55AA55AA, 1'b0, got);
        applyStimulus(0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, got);
        applyStimulus(0, 1'b1, 4'hF, 32'h1004, 32'h66BB66BB, 1'b0, got);
        applyStimulus(0, 1'b0, 4'hF, 32'h4, 32'h0, 1'b0, got);

        applyStimulus(0, 1'b1, 4'h0, 32'h8, 32'hFFFFFFFF, 1'b0, got);
        applyStimulus(0, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, got);

        we_re      = 1'b1;
        mask       = 4'hF;
        address    = 32'h04;
        store_data = 32'hCAFEF00D;
        req_a      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy_before", {31'b0, busy_a}, 32'd1);
        rst   = 1'b1;
        req_a = 1'b0;
        #1;
        checkOutput("abort_busy_now",  {31'b0, busy_a},  32'd0);
        checkOutput("abort_valid_now", {31'b0, valid_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("abort_no_valid", {31'b0, valid_a}, 32'd0);
        end
        applyStimulus(0, 1'b0, 4'hF, 32'h04, 32'h0, 1'b0, got);

        applyStimulus(0, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, got);
        applyStimulus(0, 1'b0, 4'hF, 32'h18, 32'h0, 1'b1, got);
        applyStimulus(0, 1'b1, 4'b0110, 32'h18, $urandom, 1'b0, got);
        applyStimulus(0, 1'b0, 4'hF, 32'h18, 32'h0, 1'b0, got);

        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 15));
            we  = 1'($urandom);
            m   = 4'($urandom);
            d   = $urandom;
            a   = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                a = a | (32'h1 << $urandom_range(12, 31));
            end
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(sel, we, m, a, d, 1'b1, got);
                applyStimulus(sel, 1'b0, 4'hF, 32'(idx) << 2, 32'h0, 1'b0, got);
            end else begin
                applyStimulus(sel, we, m, a, d, 1'b0, got);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
